// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder slice: FSM states, response record, parity.
// Global width defaults `WIDTH / `ADDR_WIDTH live here.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

package mem_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   typedef struct packed {
      logic              ready;
      logic              err;
      logic [`WIDTH-1:0] rdata;
   } resp_t;

   localparam int unsigned PAR_MAX_W = 64;

   // Zero-extension does not change parity, so one wide helper serves every WIDTH up to 64.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready memory request interface: the initiator drives the request, the responder the reply.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

interface mem_responder_if #(
   parameter int WIDTH      = `WIDTH,
   parameter int ADDR_WIDTH = `ADDR_WIDTH
);
   logic                  valid;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic                  ready;
   logic                  err;
   logic [WIDTH-1:0]      rdata;

   modport master (
      output valid, wr_rd, addr, wdata,
      input  ready, err, rdata
   );

   modport slave (
      input  valid, wr_rd, addr, wdata,
      output ready, err, rdata
   );
endinterface

// File: rtl/mem_responder_array.sv
// Storage for mem_responder: single write/read port, registered read data that is zero when no read.
// With MEM_RESPONDER_PARITY_EN each word carries an even-parity bit checked on read.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module mem_responder_array
   import mem_pkg::*;
#(
   parameter int WIDTH      = `WIDTH,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o
`ifdef MEM_RESPONDER_PARITY_EN
   ,
   input  logic                  wpar_i,
   output logic                  perr_o
`endif
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_d = '0;
      if (re_i) begin
         rdata_d = mem_q[addr_i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

`ifdef MEM_RESPONDER_PARITY_EN
   logic par_q [DEPTH];
   logic perr_q, perr_d;

   always_ff @(posedge clk) begin
      if (we_i) begin
         par_q[addr_i] <= wpar_i;
      end
   end

   always_comb begin
      perr_d = 1'b0;
      if (re_i) begin
         perr_d = even_parity(PAR_MAX_W'(mem_q[addr_i])) != par_q[addr_i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign perr_o = perr_q;
`endif

endmodule

// File: rtl/mem_responder.sv
// Memory responder: clears the array after reset (INIT), then answers every request one cycle later.
// Optional parity protection selected by MEM_RESPONDER_PARITY_EN (adds the perr_inject input).
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module mem_responder
   import mem_pkg::*;
#(
   parameter int WIDTH      = `WIDTH,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus,
   output logic            init_done
`ifdef MEM_RESPONDER_PARITY_EN
   ,
   input  logic            perr_inject
`endif
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH-1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  init_done_q, init_done_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;

   logic                  run;
   logic                  in_range;
   logic                  arr_we;
   logic                  arr_re;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [WIDTH-1:0]      arr_wdata;

   assign run      = (state_q == RUN);
   assign in_range = {1'b0, bus.addr} < DEPTH_W;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      init_done_d = init_done_q;
      if (!run) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == PTR_LAST) begin
            state_d     = RUN;
            init_done_d = 1'b1;
            ptr_d       = '0;
         end
      end
      ready_d = bus.valid;
      err_d   = bus.valid & (~run | ~in_range);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= INIT;
         ptr_q       <= '0;
         init_done_q <= 1'b0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

   // The sweep owns the port during INIT; bus requests there are answered with err only.
   assign arr_we    = ~run | (bus.valid & bus.wr_rd & in_range);
   assign arr_re    = run & bus.valid & ~bus.wr_rd & in_range;
   assign arr_addr  = run ? bus.addr : ptr_q;
   assign arr_wdata = run ? bus.wdata : '0;

`ifdef MEM_RESPONDER_PARITY_EN
   logic arr_wpar;
   logic arr_perr;

   assign arr_wpar = run & (even_parity(PAR_MAX_W'(bus.wdata)) ^ perr_inject);
`endif

   mem_responder_array #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (arr_addr),
      .wdata_i (arr_wdata),
      .rdata_o (bus.rdata)
`ifdef MEM_RESPONDER_PARITY_EN
      ,
      .wpar_i  (arr_wpar),
      .perr_o  (arr_perr)
`endif
   );

   assign bus.ready = ready_q;
   assign init_done = init_done_q;
`ifdef MEM_RESPONDER_PARITY_EN
   assign bus.err   = err_q | arr_perr;
`else
   assign bus.err   = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (DEPTH=16 and DEPTH=12) against a word-level reference model.
// Directed table, hand-written INIT/reset sequences, then random traffic.
module tb_mem_responder;
   import mem_pkg::*;

`ifdef MEM_RESPONDER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk;
   logic rst;
   logic done16, done12;
`ifdef MEM_RESPONDER_PARITY_EN
   logic inj16, inj12;
`endif

   mem_responder_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus16 ();
   mem_responder_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus12 ();

   mem_responder #(.WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) u_dut16 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus16),
      .init_done   (done16)
`ifdef MEM_RESPONDER_PARITY_EN
      ,
      .perr_inject (inj16)
`endif
   );

   mem_responder #(.WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus12),
      .init_done   (done12)
`ifdef MEM_RESPONDER_PARITY_EN
      ,
      .perr_inject (inj12)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycno  = 0;

   // Reference model: word contents, parity-corrupt flags, edges since reset release.
   logic [7:0] mm    [2][16];
   bit         pbad  [2][16];
   int         edges [2];
   int         dep   [2] = '{16, 12};
   resp_t      exp_r [2];
   bit         exp_d [2];

   typedef struct {
      int         sel;
      bit         wr;
      logic [3:0] a;
      logic [7:0] d;
      bit         inj;
      bit         e_err;
      logic [7:0] e_rd;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, req);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         edges[i] = 0;
         exp_r[i] = '{ready: 1'b0, err: 1'b0, rdata: 8'h00};
         exp_d[i] = 1'b0;
         for (int j = 0; j < 16; j++) begin
            mm[i][j]   = 8'h00;
            pbad[i][j] = 1'b0;
         end
      end
   endfunction

   function automatic void model_edge(input int i, input bit v, input bit wr,
                                      input logic [3:0] a, input logic [7:0] d, input bit inj);
      bit in_init;
      in_init = edges[i] < dep[i];
      edges[i]++;
      exp_r[i] = '{ready: v, err: 1'b0, rdata: 8'h00};
      if (v) begin
         if (in_init || int'(a) >= dep[i]) begin
            exp_r[i].err = 1'b1;
         end else if (wr) begin
            mm[i][a]   = d;
            pbad[i][a] = PAR && inj;
         end else begin
            exp_r[i].rdata = mm[i][a];
            exp_r[i].err   = pbad[i][a];
         end
      end
      exp_d[i] = edges[i] >= dep[i];
   endfunction

   function automatic resp_t act_resp(input int i);
      resp_t r;
      if (i == 0) r = '{ready: bus16.ready, err: bus16.err, rdata: bus16.rdata};
      else        r = '{ready: bus12.ready, err: bus12.err, rdata: bus12.rdata};
      return r;
   endfunction

   task automatic check_model();
      resp_t r;
      for (int i = 0; i < 2; i++) begin
         r = act_resp(i);
         chk($sformatf("c%0d d%0d ready", cycno, dep[i]), {7'd0, r.ready}, {7'd0, exp_r[i].ready});
         chk($sformatf("c%0d d%0d err", cycno, dep[i]), {7'd0, r.err}, {7'd0, exp_r[i].err});
         chk($sformatf("c%0d d%0d rdata", cycno, dep[i]), r.rdata, exp_r[i].rdata);
         chk($sformatf("c%0d d%0d init_done", cycno, dep[i]),
             {7'd0, (i == 0) ? done16 : done12}, {7'd0, exp_d[i]});
      end
   endtask

   task automatic drive(input int sel, input bit v, input bit wr,
                        input logic [3:0] a, input logic [7:0] d, input bit inj);
      bus16.valid = v && (sel == 0);
      bus16.wr_rd = wr;
      bus16.addr  = a;
      bus16.wdata = d;
      bus12.valid = v && (sel == 1);
      bus12.wr_rd = wr;
      bus12.addr  = a;
      bus12.wdata = d;
`ifdef MEM_RESPONDER_PARITY_EN
      inj16 = inj && (sel == 0);
      inj12 = inj && (sel == 1);
`endif
   endtask

   // Called at a falling edge; returns at the next falling edge after checking the response.
   task automatic cyc(input int sel, input bit v, input bit wr,
                      input logic [3:0] a, input logic [7:0] d, input bit inj);
      drive(sel, v, wr, a, d, inj);
      @(posedge clk);
      cycno++;
      for (int i = 0; i < 2; i++) model_edge(i, v && (sel == i), wr, a, d, inj);
      @(negedge clk);
      check_model();
   endtask

   function automatic void add(input int sel, input bit wr, input logic [3:0] a,
                               input logic [7:0] d, input bit inj, input bit e_err, input logic [7:0] e_rd);
      vec_t v;
      v = '{sel: sel, wr: wr, a: a, d: d, inj: inj, e_err: e_err, e_rd: e_rd};
      tbl.push_back(v);
   endfunction

   initial begin
      int rise16, rise12;
      resp_t r;

      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst ready16", {7'd0, bus16.ready}, 8'h00);
      chk("rst rdata16", bus16.rdata, 8'h00);
      chk("rst err16", {7'd0, bus16.err}, 8'h00);
      chk("rst done16", {7'd0, done16}, 8'h00);
      chk("rst ready12", {7'd0, bus12.ready}, 8'h00);
      chk("rst done12", {7'd0, done12}, 8'h00);
      rst = 1'b1;

      // INIT phase: request in the second INIT cycle, measure sweep length of both instances.
      rise16 = -1;
      rise12 = -1;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) begin
            cyc(0, 1'b1, 1'b1, 4'd2, 8'hFF, 1'b0);
            chk("init_req ready", {7'd0, bus16.ready}, 8'h01);
            chk("init_req err", {7'd0, bus16.err}, 8'h01);
         end else begin
            cyc(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
         end
         if (rise16 < 0 && done16) rise16 = c;
         if (rise12 < 0 && done12) rise12 = c;
      end
      chk("init_len16", 8'(rise16), 8'd16);
      chk("init_len12", 8'(rise12), 8'd12);

      for (int i = 0; i < 16; i++) cyc(0, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0);

      add(0, 0, 4'd2, 8'h00, 0, 0, 8'h00);
      add(0, 1, 4'd3, 8'hA5, 0, 0, 8'h00);
      add(0, 0, 4'd3, 8'h00, 0, 0, 8'hA5);
      for (int i = 0; i < 5; i++) begin
         add(0, 1, 4'(i), 8'(8'h11 * (i + 1)), 0, 0, 8'h00);
         add(0, 0, 4'(i), 8'h00, 0, 0, 8'(8'h11 * (i + 1)));
      end
      add(1, 1, 4'd13, 8'h77, 0, 1, 8'h00);
      add(1, 0, 4'd13, 8'h00, 0, 1, 8'h00);
      add(1, 1, 4'd11, 8'h66, 0, 0, 8'h00);
      add(1, 0, 4'd11, 8'h00, 0, 0, 8'h66);
      add(1, 1, 4'd12, 8'h99, 0, 1, 8'h00);
      add(1, 0, 4'd12, 8'h00, 0, 1, 8'h00);
      add(0, 1, 4'd5, 8'h0F, 1, 0, 8'h00);
      add(0, 0, 4'd5, 8'h00, 0, PAR, 8'h0F);
      add(0, 1, 4'd15, 8'hC3, 0, 0, 8'h00);
      add(0, 0, 4'd15, 8'h00, 0, 0, 8'hC3);

      foreach (tbl[k]) begin
         cyc(tbl[k].sel, 1'b1, tbl[k].wr, tbl[k].a, tbl[k].d, tbl[k].inj);
         r = act_resp(tbl[k].sel);
         chk($sformatf("tbl%0d ready", k), {7'd0, r.ready}, 8'h01);
         chk($sformatf("tbl%0d err", k), {7'd0, r.err}, {7'd0, tbl[k].e_err});
         chk($sformatf("tbl%0d rdata", k), r.rdata, tbl[k].e_rd);
      end
      cyc(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
      chk("idle ready16", {7'd0, bus16.ready}, 8'h00);

      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
      end

      // Reset landing on a read response.
      cyc(0, 1'b1, 1'b1, 4'd3, 8'h5A, 1'b0);
      drive(0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
      @(posedge clk);
      cycno++;
      model_edge(0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
      model_edge(1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
      #1;
      check_model();
      #1;
      rst = 1'b0;
      #1;
      chk("midrst ready16", {7'd0, bus16.ready}, 8'h00);
      chk("midrst rdata16", bus16.rdata, 8'h00);
      chk("midrst done16", {7'd0, done16}, 8'h00);
      model_reset();
      drive(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (16) cyc(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
      cyc(0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
      chk("reinit ready16", {7'd0, bus16.ready}, 8'h01);
      chk("reinit err16", {7'd0, bus16.err}, 8'h00);
      chk("reinit mem3", bus16.rdata, 8'h00);
      cyc(0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port synchronous memory that acts as the responder on the team's valid/ready memory interface (clk, valid, wr_rd, addr, wdata in; ready, rdata out).
- It answers every accepted request with `ready` exactly one cycle later, in the form the protocol checker requires.
- After reset it sweeps the array to zero before normal operation starts.
- It sits behind the bus initiator in the memory subsystem testbench and top level.

Parameters:
- WIDTH, default `WIDTH (8): data width in bits.
- ADDR_WIDTH, default `ADDR_WIDTH (4): address width in bits.
- DEPTH, default 2**ADDR_WIDTH: number of words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- valid  input  1  request present this cycle.
- wr_rd  input  1  1 = write, 0 = read.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  WIDTH  write data.
- ready  output  1  response strobe, one cycle after each accepted request.
- rdata  output  WIDTH  read data; valid while ready=1 for a read.
- err  output  1  error flag, qualified by ready.
- init_done  output  1  high once the clear sweep has finished.

Behaviour:
- Reset (rst=0, asynchronous):
  - ready=0, rdata=0, err=0, init_done=0.
  - FSM enters INIT; sweep pointer = 0.
  - Memory contents are not reset directly; the INIT sweep clears them.
- FSM has two states: INIT and RUN.
- INIT:
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - When ptr == DEPTH-1 has been written, go to RUN and set init_done=1 on the next cycle.
  - Duration is exactly DEPTH cycles after reset release.
- RUN: terminal state until the next reset.
- Acceptance:
  - No backpressure. Every cycle with valid=1 is a request, and ready=1 follows in the next cycle, in every state.
  - ready = registered copy of valid; continuous valid gives continuous ready, i.e. one transaction per cycle.
- Write in RUN, addr < DEPTH:
  - mem[addr] ← wdata at the sampling edge.
  - Next cycle: ready=1, err=0, rdata=0.
- Read in RUN, addr < DEPTH:
  - Next cycle: ready=1, rdata = mem[addr] as of the sampling edge, err=0.
- Read immediately after a write to the same address (consecutive cycles): returns the newly written data.
- Out of range (addr ≥ DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - No memory write.
  - Next cycle: ready=1, err=1, rdata=0.
- Request during INIT:
  - Not executed; the sweep is not disturbed.
  - Next cycle: ready=1, err=1, rdata=0.
- Idle cycles (valid=0 on previous edge): ready=0, err=0, rdata=0. rdata is zero whenever ready=0.
- Reset mid-operation:
  - Outputs clear immediately; any pending response is dropped.
  - The sweep restarts from address 0.
- No output is ever X after reset release; all outputs are driven from flops.

Optional Feature:
- Macro MEM_RESPONDER_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on write and written as 0 (matching zero data) during INIT.
  - On a read, a recomputed parity mismatch sets err=1 with the response; rdata still returns the stored data.
  - An extra input `perr_inject` (1 bit) flips the stored parity bit of any write issued in the same cycle.
- When undefined: no parity storage, no `perr_inject` port; err reflects only the range and INIT errors.

Decomposition:
- Shared package mem_pkg:
  - state enum {INIT, RUN};
  - resp_t struct {ready, err, rdata};
  - function for even parity over WIDTH.
- Keep `WIDTH/`ADDR_WIDTH as the global defines.
- One natural sub-module: mem_responder_array (storage, write port, registered read, optional parity bit).
- FSM and response logic stay in the top module.

Test Plan:
- Reset release, DEPTH=16:
  - init_done rises exactly 16 cycles after reset release.
  - Reads of addresses 0..15 then return 0, err=0.
- Write then read:
  - Write addr 3 ← 8'hA5; next cycle read addr 3.
  - Response: ready=1 each following cycle; read response rdata=8'hA5, err=0.
- Back-to-back traffic:
  - 10 consecutive valid cycles alternating write/read over addresses 0..4.
  - ready high for exactly the 10 following cycles; each read returns the last value written to that address.
- Request during INIT:
  - valid=1, write addr 2 ← 8'hFF in the second INIT cycle → next cycle ready=1, err=1.
  - After init_done, read addr 2 returns 0.
- Out of range:
  - DEPTH=12: write addr 13 → ready=1, err=1, no write.
  - Read addr 13 → rdata=0, err=1.
- Reset mid-burst, plus parity:
  - Drop rst during a read response → ready and rdata go to 0 immediately.
  - After re-init, mem[3] reads 0.
  - With MEM_RESPONDER_PARITY_EN: write addr 5 ← 8'h0F with perr_inject=1; read addr 5 → err=1, rdata=8'h0F.
